bullet_pool: RTL and testbench

Parametrised multi-slot player-bullet manager; next generation of the single-bullet block.
- Holds up to N_BULLETS concurrent bullets on an X_W x Y_W playfield grid.
- Allocates a free slot on each accepted shoot request, advances every flying bullet upward on a shared movement tick, and retires bullets on hit or top-of-screen.
- Enforces a tick-based fire cooldown.
- Sits between player input/ship logic and the collision and display units.

---
 rtl/space_inv_pkg.sv | 23 ++
 rtl/bullet_pool_if.sv | 30 +++
 rtl/bullet_slot.sv | 46 ++++
 rtl/bullet_pool.sv | 92 +++++++++
 tb/tb_bullet_pool.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/space_inv_pkg.sv
// Shared playfield geometry, timing defaults and bullet record for the space-invaders blocks.
package space_inv_pkg;

  localparam int unsigned X_W_DEF            = 5;
  localparam int unsigned Y_W_DEF            = 4;
  localparam int unsigned SPAWN_Y_DEF        = 12;
  localparam int unsigned IDLE_Y_DEF         = 15;
  localparam int unsigned TICK_CYCLES_36M    = 90000;
  localparam int unsigned N_BULLETS_DEF      = 4;
  localparam int unsigned COOLDOWN_TICKS_DEF = 3;

  typedef struct packed {
    logic               flying;
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
  } bullet_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Bullet pool bus: player/collision requests in, per-slot bullet state out.
interface bullet_pool_if
  import space_inv_pkg::*;
#(
  parameter int unsigned N_BULLETS = N_BULLETS_DEF,
  parameter int unsigned X_W       = X_W_DEF,
  parameter int unsigned Y_W       = Y_W_DEF
);

  logic                   enable;
  logic                   shoot;
  logic [X_W-1:0]         ship_x;
  logic [N_BULLETS-1:0]   hit;
  logic [N_BULLETS-1:0]   bullet_flying;
  logic [N_BULLETS*X_W-1:0] bullet_x;
  logic [N_BULLETS*Y_W-1:0] bullet_y;
  logic                   fire_ack;
  logic                   slot_full;

  modport master (
    output enable, shoot, ship_x, hit,
    input  bullet_flying, bullet_x, bullet_y, fire_ack, slot_full
  );

  modport slave (
    input  enable, shoot, ship_x, hit,
    output bullet_flying, bullet_x, bullet_y, fire_ack, slot_full
  );

endinterface

// File: rtl/bullet_slot.sv
// One bullet register: retire on hit/top row, move up on tick, load on fire.
module bullet_slot
  import space_inv_pkg::*;
#(
  parameter int unsigned X_W     = X_W_DEF,
  parameter int unsigned Y_W     = Y_W_DEF,
  parameter int unsigned SPAWN_Y = SPAWN_Y_DEF,
  parameter int unsigned IDLE_Y  = IDLE_Y_DEF
) (
  input  logic           clk_36MHz,
  input  logic           reset,
  input  logic           enable,
  input  logic           tick,
  input  logic           hit,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  output logic           flying,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [Y_W-1:0] SPAWN_V = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0] IDLE_V  = Y_W'(IDLE_Y);

  // Retiring at row 0 outranks moving, so y never wraps below zero.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      flying <= 1'b0;
      x      <= '0;
      y      <= IDLE_V;
    end else if (enable) begin
      if (flying && (hit || (y == '0))) begin
        flying <= 1'b0;
        x      <= '0;
        y      <= IDLE_V;
      end else if (flying && tick) begin
        y <= y - 1'b1;
      end else if (!flying && load) begin
        flying <= 1'b1;
        x      <= load_x;
        y      <= SPAWN_V;
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot player bullet manager: free-slot allocation, movement tick and fire cooldown.
module bullet_pool
  import space_inv_pkg::*;
#(
  parameter int unsigned N_BULLETS      = N_BULLETS_DEF,
  parameter int unsigned X_W            = X_W_DEF,
  parameter int unsigned Y_W            = Y_W_DEF,
  parameter int unsigned SPAWN_Y        = SPAWN_Y_DEF,
  parameter int unsigned IDLE_Y         = IDLE_Y_DEF,
  parameter int unsigned TICK_CYCLES    = TICK_CYCLES_36M,
  parameter int unsigned COOLDOWN_TICKS = COOLDOWN_TICKS_DEF
) (
  input  logic          clk_36MHz,
  input  logic          reset,
  bullet_pool_if.slave  bus
);

  localparam int unsigned TW = cnt_w(TICK_CYCLES);
  localparam int unsigned CW = cnt_w(COOLDOWN_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN_TICKS);

  logic [TW-1:0]            tick_cnt;
  logic [CW-1:0]            cooldown;
  logic                     tick;
  logic                     accept;
  logic                     fire_ack_q;
  logic                     found;
  logic [N_BULLETS-1:0]     flying;
  logic [N_BULLETS-1:0]     load;
  logic [N_BULLETS*X_W-1:0] xs;
  logic [N_BULLETS*Y_W-1:0] ys;

  assign tick   = bus.enable && (tick_cnt == TICK_LAST);
  assign accept = bus.enable && bus.shoot && (cooldown == '0) && !(&flying);

  // Lowest-index idle slot; a slot retiring this cycle still reads as flying.
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      if (!flying[i] && !found) begin
        load[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      tick_cnt   <= '0;
      cooldown   <= '0;
      fire_ack_q <= 1'b0;
    end else if (bus.enable) begin
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      fire_ack_q <= accept;
      if (accept)
        cooldown <= CD_LOAD;
      else if (tick && (cooldown != '0))
        cooldown <= cooldown - 1'b1;
    end else begin
      fire_ack_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .X_W     (X_W),
      .Y_W     (Y_W),
      .SPAWN_Y (SPAWN_Y),
      .IDLE_Y  (IDLE_Y)
    ) u_slot (
      .clk_36MHz (clk_36MHz),
      .reset     (reset),
      .enable    (bus.enable),
      .tick      (tick),
      .hit       (bus.hit[i]),
      .load      (load[i] && accept),
      .load_x    (bus.ship_x),
      .flying    (flying[i]),
      .x         (xs[i*X_W +: X_W]),
      .y         (ys[i*Y_W +: Y_W])
    );
  end

  assign bus.bullet_flying = flying;
  assign bus.bullet_x      = xs;
  assign bus.bullet_y      = ys;
  assign bus.fire_ack      = fire_ack_q;
  assign bus.slot_full     = &flying;

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: two instances (cooldown 0 and 2) against a per-cycle behavioural model.
module tb_bullet_pool;
  import space_inv_pkg::*;

  localparam int N  = 4;
  localparam int XW = 5;
  localparam int YW = 4;
  localparam int TC = 4;

  logic          clk_36MHz = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b0;
  logic          shoot     = 1'b0;
  logic [XW-1:0] ship_x    = '0;
  logic [N-1:0]  hit       = '0;

  always #5 clk_36MHz = ~clk_36MHz;

  bullet_pool_if #(.N_BULLETS(N), .X_W(XW), .Y_W(YW)) bus_a ();
  bullet_pool_if #(.N_BULLETS(N), .X_W(XW), .Y_W(YW)) bus_b ();

  assign bus_a.enable = enable;
  assign bus_a.shoot  = shoot;
  assign bus_a.ship_x = ship_x;
  assign bus_a.hit    = hit;
  assign bus_b.enable = enable;
  assign bus_b.shoot  = shoot;
  assign bus_b.ship_x = ship_x;
  assign bus_b.hit    = hit;

  bullet_pool #(.N_BULLETS(N), .X_W(XW), .Y_W(YW), .SPAWN_Y(12), .IDLE_Y(15),
                .TICK_CYCLES(TC), .COOLDOWN_TICKS(0)) dut_a (
    .clk_36MHz (clk_36MHz), .reset (reset), .bus (bus_a));

  bullet_pool #(.N_BULLETS(N), .X_W(XW), .Y_W(YW), .SPAWN_Y(12), .IDLE_Y(15),
                .TICK_CYCLES(TC), .COOLDOWN_TICKS(2)) dut_b (
    .clk_36MHz (clk_36MHz), .reset (reset), .bus (bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 mirrors dut_a (no cooldown), index 1 dut_b (cooldown 2).
  bullet_t m_slot [2][N];
  int      m_cnt  [2];
  int      m_cd   [2];
  bit      m_ack  [2];
  bit      m_valid = 1'b0;

  always @(posedge clk_36MHz) begin
    int cdmax, free;
    bit tk, acc;
    for (int d = 0; d < 2; d++) begin
      cdmax = (d == 0) ? 0 : 2;
      if (reset) begin
        for (int i = 0; i < N; i++) m_slot[d][i] = '{1'b0, 5'd0, 4'd15};
        m_cnt[d] = 0;
        m_cd[d]  = 0;
        m_ack[d] = 1'b0;
      end else if (enable) begin
        tk   = (m_cnt[d] == TC - 1);
        free = -1;
        for (int i = 0; i < N; i++)
          if (!m_slot[d][i].flying && free < 0) free = i;
        acc = shoot && (m_cd[d] == 0) && (free >= 0);
        for (int i = 0; i < N; i++) begin
          if (m_slot[d][i].flying) begin
            if (hit[i] || m_slot[d][i].y == 4'd0) m_slot[d][i] = '{1'b0, 5'd0, 4'd15};
            else if (tk) m_slot[d][i].y = m_slot[d][i].y - 4'd1;
          end
        end
        if (acc) m_slot[d][free] = '{1'b1, ship_x, 4'd12};
        if (acc) m_cd[d] = cdmax;
        else if (tk && m_cd[d] > 0) m_cd[d] = m_cd[d] - 1;
        m_cnt[d] = (m_cnt[d] + 1) % TC;
        m_ack[d] = acc;
      end else begin
        m_ack[d] = 1'b0;
      end
    end
    if (reset) m_valid = 1'b1;
  end

  task automatic cmp_dut(input string tag, input int d, input logic [N-1:0] fl,
                         input logic [N*XW-1:0] xv, input logic [N*YW-1:0] yv,
                         input logic ack, input logic full);
    logic [N-1:0]    ef;
    logic [N*XW-1:0] ex;
    logic [N*YW-1:0] ey;
    for (int i = 0; i < N; i++) begin
      ef[i]             = m_slot[d][i].flying;
      ex[i*XW +: XW]    = m_slot[d][i].x;
      ey[i*YW +: YW]    = m_slot[d][i].y;
    end
    check({tag, "_flying"}, fl, ef);
    check({tag, "_x"}, xv, ex);
    check({tag, "_y"}, yv, ey);
    check({tag, "_fire_ack"}, ack, m_ack[d]);
    check({tag, "_slot_full"}, full, &ef);
  endtask

  always @(negedge clk_36MHz) begin
    if (m_valid) begin
      cmp_dut("A", 0, bus_a.bullet_flying, bus_a.bullet_x, bus_a.bullet_y, bus_a.fire_ack, bus_a.slot_full);
      cmp_dut("B", 1, bus_b.bullet_flying, bus_b.bullet_x, bus_b.bullet_y, bus_b.fire_ack, bus_b.slot_full);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_36MHz);
  endtask

  initial begin
    int k, acks, nb, first, second;

    // Reset state
    reset = 1'b1; enable = 1'b1;
    step(2);
    check("reset_flying", bus_a.bullet_flying, 0);
    check("reset_y", bus_a.bullet_y, 16'hFFFF);
    check("reset_x", bus_a.bullet_x, 0);
    check("reset_ack", bus_a.fire_ack, 0);
    reset = 1'b0;

    // Reset mid-flight
    ship_x = 5'd3; shoot = 1'b1;
    step(1);
    shoot = 1'b0;
    check("t1_ack", bus_a.fire_ack, 1);
    check("t1_flying", bus_a.bullet_flying, 4'b0001);
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t1_rst_flying_a", bus_a.bullet_flying, 0);
    check("t1_rst_flying_b", bus_b.bullet_flying, 0);
    check("t1_rst_y", bus_a.bullet_y, 16'hFFFF);
    check("t1_rst_x", bus_a.bullet_x, 0);
    check("t1_rst_ack", bus_a.fire_ack, 0);

    // Single bullet flight: tick phase is 0 at the accept edge, so row 0 is hit 47 cycles later
    ship_x = 5'd7; shoot = 1'b1;
    step(1);
    shoot = 1'b0;
    check("t2_ack", bus_a.fire_ack, 1);
    check("t2_x0", bus_a.bullet_x[XW-1:0], 7);
    check("t2_y0", bus_a.bullet_y[YW-1:0], 12);
    k = 0;
    while (k < 100 && bus_a.bullet_y[YW-1:0] != 4'd0) begin
      step(1);
      k++;
    end
    check("t2_cycles_to_row0", k, 47);
    step(1);
    check("t2_retired_flying", bus_a.bullet_flying[0], 0);
    check("t2_retired_y", bus_a.bullet_y[YW-1:0], 15);
    check("t2_retired_x", bus_a.bullet_x[XW-1:0], 0);

    // Pool fill with held shoot (dut_a has no cooldown)
    ship_x = 5'd20; shoot = 1'b1; acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus_a.fire_ack) acks++;
    end
    check("t3_ack_count", acks, 4);
    check("t3_slot_full", bus_a.slot_full, 1);

    // Hit and shoot in the same cycle while full
    hit = 4'b0100;
    step(1);
    hit = '0;
    check("t5_no_fire", bus_a.fire_ack, 0);
    check("t5_slot2_free", bus_a.bullet_flying, 4'b1011);
    check("t5_slot2_idle_y", bus_a.bullet_y[2*YW +: YW], 15);
    step(1);
    shoot = 1'b0;
    check("t5_refire", bus_a.fire_ack, 1);
    check("t5_refill", bus_a.bullet_flying, 4'b1111);
    check("t5_slot2_y", bus_a.bullet_y[2*YW +: YW], 12);

    // Cooldown of 2 ticks on dut_b with shoot held from a fresh reset
    reset = 1'b1;
    step(1);
    reset = 1'b0; shoot = 1'b1; ship_x = 5'd9;
    nb = 0; first = -1; second = -1; acks = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1);
      if (bus_a.fire_ack) acks++;
      if (bus_b.fire_ack) begin
        nb++;
        if (first < 0) first = j;
        else if (second < 0) second = j;
      end
    end
    shoot = 1'b0;
    check("t4_b_ack_count", nb, 3);
    check("t4_b_gap", second - first, 8);
    check("t4_a_ack_count", acks, 4);

    // Pause mid-flight: hit and shoot must be ignored
    step(3);
    enable = 1'b0; hit = 4'hF; shoot = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step(1);
      check("t6_pause_ack", bus_a.fire_ack, 0);
    end
    enable = 1'b1; hit = '0; shoot = 1'b0;
    check("t6_a_still_flying", bus_a.bullet_flying, 4'b1111);
    check("t6_b_still_flying", bus_b.bullet_flying, 4'b0111);
    step(80);
    check("t6_a_all_retired", bus_a.bullet_flying, 0);
    check("t6_b_all_retired", bus_b.bullet_flying, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
